// File: rtl/merge_2to1_if.sv
// Bundle of the three FIFO-facing ports of one merge stage: two upstream heads and the downstream write side.
// The stage itself connects through the slave modport; the environment driving it uses master.
interface merge_2to1_if #(
    parameter int unsigned P_WIDTH     = 32,
    parameter int unsigned P_CNT_WIDTH = 16
);
    logic [P_WIDTH-1:0]     i_a_data;
    logic                   i_a_empty;
    logic                   o_a_deq;
    logic [P_WIDTH-1:0]     i_b_data;
    logic                   i_b_empty;
    logic                   o_b_deq;
    logic [P_WIDTH-1:0]     o_data;
    logic                   o_enq;
    logic                   i_full;
    logic [P_CNT_WIDTH-1:0] o_stream_cnt;

    modport slave (
        input  i_a_data, i_a_empty, i_b_data, i_b_empty, i_full,
        output o_a_deq, o_b_deq, o_data, o_enq, o_stream_cnt
    );

    modport master (
        output i_a_data, i_a_empty, i_b_data, i_b_empty, i_full,
        input  o_a_deq, o_b_deq, o_data, o_enq, o_stream_cnt
    );
endinterface

// File: rtl/merge_2to1.sv
// Two-input merge stage of the sort tree: merges two ascending, zero-terminated record streams
// into one ascending stream through a single output register, counting completed streams.
module merge_2to1 #(
    parameter int unsigned P_WIDTH     = 32,
    parameter int unsigned P_CNT_WIDTH = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    merge_2to1_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_MERGE   = 2'd0,
        ST_DRAIN_A = 2'd1,
        ST_DRAIN_B = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   out_valid_q;
    logic [P_WIDTH-1:0]     data_q, data_d;
    logic [P_CNT_WIDTH-1:0] cnt_q;
    logic                   load;
    logic                   a_deq, b_deq;
    logic                   ready, enq;
    logic                   a_zero, b_zero;

    // The output register may take a new record when it is empty or being drained this cycle.
    assign ready  = !out_valid_q || !bus.i_full;
    assign enq    = out_valid_q && !bus.i_full && !i_rst;
    assign a_zero = (bus.i_a_data == '0);
    assign b_zero = (bus.i_b_data == '0);

    // Next-state, dequeue and load decode.
    always_comb begin
        state_d = state_q;
        a_deq   = 1'b0;
        b_deq   = 1'b0;
        load    = 1'b0;
        data_d  = '0;
        if (!i_rst && ready) begin
            unique case (state_q)
                ST_MERGE: begin
                    if (!bus.i_a_empty && !bus.i_b_empty) begin
                        if (a_zero && b_zero) begin
                            a_deq = 1'b1;
                            b_deq = 1'b1;
                            load  = 1'b1;
                        end else if (a_zero) begin
                            a_deq   = 1'b1;
                            state_d = ST_DRAIN_B;
                        end else if (b_zero) begin
                            b_deq   = 1'b1;
                            state_d = ST_DRAIN_A;
                        end else if (bus.i_a_data <= bus.i_b_data) begin
                            a_deq  = 1'b1;
                            load   = 1'b1;
                            data_d = bus.i_a_data;
                        end else begin
                            b_deq  = 1'b1;
                            load   = 1'b1;
                            data_d = bus.i_b_data;
                        end
                    end
                end
                ST_DRAIN_A: begin
                    if (!bus.i_a_empty) begin
                        a_deq  = 1'b1;
                        load   = 1'b1;
                        data_d = bus.i_a_data;
                        if (a_zero) state_d = ST_MERGE;
                    end
                end
                ST_DRAIN_B: begin
                    if (!bus.i_b_empty) begin
                        b_deq  = 1'b1;
                        load   = 1'b1;
                        data_d = bus.i_b_data;
                        if (b_zero) state_d = ST_MERGE;
                    end
                end
                default: state_d = ST_MERGE;
            endcase
        end
    end

    // State, output register and stream counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_MERGE;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                data_q      <= data_d;
                out_valid_q <= 1'b1;
            end else if (enq) begin
                out_valid_q <= 1'b0;
            end
            if (enq && (data_q == '0)) cnt_q <= cnt_q + P_CNT_WIDTH'(1);
        end
    end

    assign bus.o_a_deq      = a_deq;
    assign bus.o_b_deq      = b_deq;
    assign bus.o_enq        = enq;
    assign bus.o_data       = data_q;
    assign bus.o_stream_cnt = cnt_q;

endmodule

// File: tb/tb_merge_2to1.sv
// Directed bench for merge_2to1: upstream/downstream FIFOs modelled as queues, hand-computed expectations.
// A second instance with a 2-bit stream counter shares the same stimulus to exercise counter wrap.
module tb_merge_2to1;

    logic clk;
    logic rst;

    merge_2to1_if #(.P_WIDTH(32), .P_CNT_WIDTH(16)) bus ();
    merge_2to1_if #(.P_WIDTH(32), .P_CNT_WIDTH(2))  bus2 ();

    merge_2to1 #(.P_WIDTH(32), .P_CNT_WIDTH(16)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    merge_2to1 #(.P_WIDTH(32), .P_CNT_WIDTH(2)) u_dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2.slave)
    );

    assign bus2.i_a_data  = bus.i_a_data;
    assign bus2.i_a_empty = bus.i_a_empty;
    assign bus2.i_b_data  = bus.i_b_data;
    assign bus2.i_b_empty = bus.i_b_empty;
    assign bus2.i_full    = bus.i_full;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a_fifo [$];
    logic [31:0] b_fifo [$];
    logic [31:0] out_q  [$];
    logic [31:0] exp_q  [$];
    logic        a_hold, b_hold, full_f;
    logic        s_a, s_b, s_enq;
    logic [31:0] s_data;
    logic [31:0] deq_log;
    int          cyc, first_deq, first_enq;
    int          n_vec, n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_len"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < out_q.size()) chk($sformatf("%s_out%0d", tag, i), 64'(out_q[i]), 64'(exp_q[i]));
            else                  chk($sformatf("%s_out%0d", tag, i), 64'hDEAD_BEEF, 64'(exp_q[i]));
        end
    endtask

    task automatic drive();
        bus.i_a_empty = (a_fifo.size() == 0) || a_hold;
        bus.i_a_data  = (a_fifo.size() != 0) ? a_fifo[0] : 32'd0;
        bus.i_b_empty = (b_fifo.size() == 0) || b_hold;
        bus.i_b_data  = (b_fifo.size() != 0) ? b_fifo[0] : 32'd0;
        bus.i_full    = full_f;
    endtask

    // One clock: drive heads, sample outputs mid-cycle, then apply pops after the edge.
    task automatic step();
        drive();
        @(negedge clk);
        s_a    = bus.o_a_deq;
        s_b    = bus.o_b_deq;
        s_enq  = bus.o_enq;
        s_data = bus.o_data;
        if (s_enq) begin
            out_q.push_back(s_data);
            if (first_enq < 0) first_enq = cyc;
        end
        if (s_a || s_b) begin
            deq_log = {deq_log[29:0], s_b, s_a};
            if (first_deq < 0) first_deq = cyc;
        end
        @(posedge clk);
        #1;
        if (s_a && a_fifo.size() != 0) void'(a_fifo.pop_front());
        if (s_b && b_fifo.size() != 0) void'(b_fifo.pop_front());
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic begin_scn();
        out_q.delete();
        exp_q.delete();
        deq_log   = '0;
        cyc       = 0;
        first_deq = -1;
        first_enq = -1;
        a_hold    = 1'b0;
        b_hold    = 1'b0;
        full_f    = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        begin_scn();

        // Reset with heads present: nothing may be popped or written.
        a_fifo = '{32'd1, 32'd4, 32'd7, 32'd0};
        b_fifo = '{32'd2, 32'd3, 32'd9, 32'd0};
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_adeq", 64'(s_a), 64'd0);
            chk("rst_bdeq", 64'(s_b), 64'd0);
            chk("rst_enq", 64'(s_enq), 64'd0);
        end
        chk("rst_data", 64'(bus.o_data), 64'd0);
        chk("rst_cnt", 64'(bus.o_stream_cnt), 64'd0);
        rst = 1'b0;

        // Basic merge.
        begin_scn();
        run(16);
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd7, 32'd9, 32'd0};
        chk_seq("basic");
        chk("basic_cnt", 64'(bus.o_stream_cnt), 64'd1);
        chk("basic_first_deq", 64'(first_deq), 64'd0);
        chk("basic_latency", 64'(first_enq - first_deq), 64'd1);

        // Ties go to A; A's terminator switches to draining B.
        begin_scn();
        a_fifo = '{32'd5, 32'd5, 32'd0};
        b_fifo = '{32'd5, 32'd0};
        run(12);
        exp_q = '{32'd5, 32'd5, 32'd5, 32'd0};
        chk_seq("tie");
        chk("tie_deq_order", 64'(deq_log), 64'b01_01_01_10_10);
        chk("tie_cnt", 64'(bus.o_stream_cnt), 64'd2);

        // Backpressure on cycles 3..6 holds record 3 with no pops.
        begin_scn();
        a_fifo = '{32'd1, 32'd4, 32'd7, 32'd0};
        b_fifo = '{32'd2, 32'd3, 32'd9, 32'd0};
        for (int c = 0; c < 20; c++) begin
            full_f = (c >= 3) && (c <= 6);
            step();
            if (c >= 3 && c <= 6) begin
                chk($sformatf("bp_hold%0d", c), 64'(s_data), 64'd3);
                chk($sformatf("bp_deq%0d", c), 64'({s_a, s_b}), 64'd0);
                chk($sformatf("bp_enq%0d", c), 64'(s_enq), 64'd0);
            end
        end
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd7, 32'd9, 32'd0};
        chk_seq("bp");
        chk("bp_cnt", 64'(bus.o_stream_cnt), 64'd3);

        // B empty for 4 cycles stalls MERGE; DRAIN_B then proceeds with A empty.
        begin_scn();
        a_fifo = '{32'd6, 32'd0};
        b_fifo = '{32'd8, 32'd0};
        b_hold = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("estall_deq%0d", c), 64'({s_a, s_b}), 64'd0);
            chk($sformatf("estall_enq%0d", c), 64'(s_enq), 64'd0);
        end
        b_hold = 1'b0;
        run(12);
        exp_q = '{32'd6, 32'd8, 32'd0};
        chk_seq("estall");
        chk("estall_cnt", 64'(bus.o_stream_cnt), 64'd4);

        // Back-to-back stream pairs; A's second stream waits for B's second stream.
        begin_scn();
        a_fifo = '{32'd3, 32'd0, 32'd1, 32'd0};
        b_fifo = '{32'd0, 32'd2, 32'd0};
        run(14);
        exp_q = '{32'd3, 32'd0, 32'd1, 32'd2, 32'd0};
        chk_seq("b2b");
        chk("b2b_deq_order", 64'(deq_log), 64'b10_01_01_01_01_10_10);
        chk("b2b_cnt", 64'(bus.o_stream_cnt), 64'd6);
        chk("b2b_cnt2_wrap", 64'(bus2.o_stream_cnt), 64'd2);

        // Reset while the output register holds a record in DRAIN_A.
        begin_scn();
        a_fifo = '{32'd10, 32'd20, 32'd0};
        b_fifo = '{32'd0};
        run(2);
        rst = 1'b1;
        step();
        chk("mrst_enq", 64'(s_enq), 64'd0);
        chk("mrst_adeq", 64'(s_a), 64'd0);
        rst = 1'b0;
        chk("mrst_cnt", 64'(bus.o_stream_cnt), 64'd0);
        chk("mrst_cnt2", 64'(bus2.o_stream_cnt), 64'd0);
        step();
        chk("post_rst_enq", 64'(s_enq), 64'd0);
        chk("post_rst_adeq", 64'(s_a), 64'd0);

        // Five stream pairs after reset; the 2-bit counter wraps to 1.
        begin_scn();
        a_fifo.delete();
        b_fifo.delete();
        for (int p = 0; p < 5; p++) begin
            a_fifo.push_back(32'(p + 1));
            a_fifo.push_back(32'd0);
            b_fifo.push_back(32'(p + 2));
            b_fifo.push_back(32'd0);
            exp_q.push_back(32'(p + 1));
            exp_q.push_back(32'(p + 2));
            exp_q.push_back(32'd0);
        end
        run(30);
        chk_seq("pairs");
        chk("pairs_cnt", 64'(bus.o_stream_cnt), 64'd5);
        chk("pairs_cnt2", 64'(bus2.o_stream_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
